// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, registers ROM data into the IR, and hands it to decode via valid/ready.
// Optional build macro FETCH_PERF_EN adds a 16-bit fetch counter on port perf_fetch_cnt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] pc_out,
  input  logic [15:0] rom_data,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        decode_ready,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        halt_req,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] perf_fetch_cnt
`endif
);

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        can_load;

  assign can_load = ~instr_valid | decode_ready;
  assign pc_out   = pc;
  assign halted   = (state == S_HALTED);

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
  // reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
    end else if (state == S_RUN) begin
      if (halt_req) begin
        // A pending instruction survives the halt until decode takes it.
        state       <= S_HALTED;
        instr_valid <= instr_valid & ~decode_ready;
      end else if (branch_taken) begin
        pc          <= branch_target & 16'hFFFE;
        instr_valid <= 1'b0;
      end else if (can_load) begin
        instr       <= rom_data;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 16'd2;
      end
    end else begin
      instr_valid <= instr_valid & ~decode_ready;
    end
  end

`ifdef FETCH_PERF_EN
  // Counts IR loads only; branch, halt and stall edges leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= 16'h0000;
    end else if (state == S_RUN && !halt_req && !branch_taken && can_load) begin
      perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: stream, stall, branch, halt, PC wrap and (optionally) the perf counter.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, decode_ready, branch_taken, halt_req;
  logic [15:0] branch_target;
  logic [15:0] pc_out, rom_data, instr, instr_pc;
  logic        instr_valid, halted;

  logic        w_reset;
  logic [15:0] w_pc_out, w_rom_data, w_instr, w_instr_pc;
  logic        w_instr_valid, w_halted;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt, w_perf_fetch_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // ROM image: word at byte address a is {4'hA, a[12:1]}, so ROM[0..6] = A000..A003, ROM[0x10] = A008, ROM[FFFE] = AFFF.
  function automatic logic [15:0] rom(input logic [15:0] a);
    return {4'hA, a[12:1]};
  endfunction

  assign rom_data   = rom(pc_out);
  assign w_rom_data = rom(w_pc_out);

  fetch_unit #(.RESET_PC(16'h0000)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .pc_out        (pc_out),
    .rom_data      (rom_data),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt_req      (halt_req),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) u_dut_wrap (
    .clk           (clk),
    .reset         (w_reset),
    .pc_out        (w_pc_out),
    .rom_data      (w_rom_data),
    .instr         (w_instr),
    .instr_pc      (w_instr_pc),
    .instr_valid   (w_instr_valid),
    .decode_ready  (1'b1),
    .branch_taken  (1'b0),
    .branch_target (16'h0000),
    .halt_req      (1'b0),
    .halted        (w_halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(w_perf_fetch_cnt)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle away from it before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    w_reset       = 1'b1;
    decode_ready  = 1'b1;
    branch_taken  = 1'b0;
    halt_req      = 1'b0;
    branch_target = 16'h0000;
    step();
    step();

    // Reset state
    check("rst_pc", pc_out, 16'h0000);
    check("rst_instr", instr, 16'h0000);
    check("rst_instr_pc", instr_pc, 16'h0000);
    check("rst_valid", {15'd0, instr_valid}, 16'd1 - 16'd1);
    check("rst_halted", {15'd0, halted}, 16'h0000);
    check("rst_wrap_pc", w_pc_out, 16'hFFFE);
`ifdef FETCH_PERF_EN
    check("rst_perf", perf_fetch_cnt, 16'h0000);
`endif

    // Stream, then a 3-cycle stall while A001 is held
    reset = 1'b0;
    step();
    check("s0_instr", instr, 16'hA000);
    check("s0_ipc", instr_pc, 16'h0000);
    check("s0_valid", {15'd0, instr_valid}, 16'h0001);
    step();
    check("s1_instr", instr, 16'hA001);
    check("s1_ipc", instr_pc, 16'h0002);
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_instr", instr, 16'hA001);
      check("stall_ipc", instr_pc, 16'h0002);
      check("stall_pc", pc_out, 16'h0004);
      check("stall_valid", {15'd0, instr_valid}, 16'h0001);
    end
    decode_ready = 1'b1;
    step();
    check("s2_instr", instr, 16'hA002);
    check("s2_ipc", instr_pc, 16'h0004);
    step();
    check("s3_instr", instr, 16'hA003);
    check("s3_ipc", instr_pc, 16'h0006);
    check("s3_pc", pc_out, 16'h0008);

    // Branch while A001 is valid: one bubble, odd target bit dropped
    do_reset();
    step();
    step();
    check("br_pre_instr", instr, 16'hA001);
    branch_taken  = 1'b1;
    branch_target = 16'h0011;
    step();
    branch_taken = 1'b0;
    check("br_bubble_valid", {15'd0, instr_valid}, 16'h0000);
    check("br_pc", pc_out, 16'h0010);
    step();
    check("br_instr", instr, 16'hA008);
    check("br_ipc", instr_pc, 16'h0010);
    check("br_valid", {15'd0, instr_valid}, 16'h0001);

    // Halt together with branch while a pending instruction is stalled
    decode_ready  = 1'b0;
    halt_req      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    step();
    halt_req = 1'b0;
    check("h_halted", {15'd0, halted}, 16'h0001);
    check("h_pc", pc_out, 16'h0012);
    check("h_instr", instr, 16'hA008);
    check("h_valid", {15'd0, instr_valid}, 16'h0001);
    step();
    check("h_hold_valid", {15'd0, instr_valid}, 16'h0001);
    check("h_hold_pc", pc_out, 16'h0012);
    decode_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("h_drain_valid", {15'd0, instr_valid}, 16'h0000);
      check("h_drain_pc", pc_out, 16'h0012);
      check("h_drain_halted", {15'd0, halted}, 16'h0001);
    end
    branch_taken = 1'b0;
    reset        = 1'b1;
    step();
    reset = 1'b0;
    check("h_rst_halted", {15'd0, halted}, 16'h0000);
    check("h_rst_pc", pc_out, 16'h0000);
    step();
    check("h_resume_instr", instr, 16'hA000);
    check("h_resume_valid", {15'd0, instr_valid}, 16'h0001);

    // PC wrap from FFFE to 0000
    w_reset = 1'b0;
    step();
    check("w_ipc0", w_instr_pc, 16'hFFFE);
    check("w_instr0", w_instr, 16'hAFFF);
    check("w_pc0", w_pc_out, 16'h0000);
    step();
    check("w_ipc1", w_instr_pc, 16'h0000);
    check("w_instr1", w_instr, 16'hA000);

`ifdef FETCH_PERF_EN
    // 5 fetches, 2-cycle stall, 1 branch bubble, then reset mid-run
    do_reset();
    decode_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    decode_ready = 1'b0;
    step();
    step();
    decode_ready  = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 16'h0020;
    step();
    branch_taken = 1'b0;
    check("perf_cnt", perf_fetch_cnt, 16'd5);
    step();
    check("perf_after_bubble", perf_fetch_cnt, 16'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("perf_rst", perf_fetch_cnt, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 16-bit RISC CPU, sitting directly upstream of the instruction ROM. Owns the program counter: drives the ROM address, captures the returned 16-bit instruction into an instruction register, and hands it to decode with a valid/ready handshake. Handles decode back-pressure, branch redirects with a one-bubble flush, and a terminal halt.

## Interface
- `RESET_PC`, default `16'h0000`: PC value loaded on reset. Must be even.
- `clk`, input, 1: single system clock. All state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `pc_out`, output, 16: current PC, byte address. Drives the ROM address directly.
- `rom_data`, input, 16: instruction word from the ROM. Combinational read, valid in the same cycle as `pc_out`.
- `instr`, output, 16: registered instruction to decode.
- `instr_pc`, output, 16: PC that `instr` was fetched from.
- `instr_valid`, output, 1: `instr` and `instr_pc` hold an unconsumed instruction.
- `decode_ready`, input, 1: decode accepts `instr` this cycle.
- `branch_taken`, input, 1: redirect request from execute.
- `branch_target`, input, 16: redirect address. Bit 0 is forced to 0.
- `halt_req`, input, 1: stop fetching permanently. Only reset clears the halt.
- `halted`, output, 1: fetch unit is in the HALTED state.
- `perf_fetch_cnt`, output, 16: only present with `FETCH_PERF_EN`; see Configuration.

## Operation
- Two states, RUN and HALTED. Reset enters RUN.
- Define `accept = instr_valid & decode_ready`.
- Define `can_load = ~instr_valid | decode_ready`.
- Priority in RUN, highest first:
  1. `halt_req`
     - Go to HALTED.
     - PC is frozen.
     - `instr_valid <= instr_valid & ~decode_ready`. A pending instruction is held until it is accepted.
     - No new fetch.
  2. `branch_taken`
     - `pc <= {branch_target[15:1], 1'b0}`.
     - `instr_valid <= 0`. This flushes the wrong-path instruction even if it was not yet accepted.
     - No capture this edge.
  3. `can_load`
     - `instr <= rom_data`, `instr_pc <= pc`, `instr_valid <= 1`.
     - `pc <= pc + 2`.
  4. Otherwise (stall): all registers hold.
- HALTED:
  - PC is frozen.
  - `branch_taken` is ignored.
  - `instr_valid` clears on `accept` and never re-asserts.
  - `halted = 1`.
- PC arithmetic is modulo 2^16: `16'hFFFE + 2` becomes `16'h0000`. No error is flagged.

## Timing
- Reset values:
  - `pc_out = RESET_PC`
  - `instr = 16'h0000`
  - `instr_pc = 16'h0000`
  - `instr_valid = 0`
  - `halted = 0`
  - `perf_fetch_cnt = 0`
- Reset asserted mid-operation overrides every other input on that edge.
- First fetch: the first edge with `reset` low captures ROM[`RESET_PC`]. `instr_valid` is 1 in the following cycle.
- Throughput: one instruction per cycle while `decode_ready` is held high.
- Fetch-to-decode latency: 1 cycle (ROM read is combinational, then the IR register).
- Redirect penalty: 1 bubble.
  - Edge N samples `branch_taken`; `instr_valid` is 0 in cycle N+1.
  - Edge N+1 captures ROM[target]; it is valid in cycle N+2.
- Back-pressure:
  - With `instr_valid=1` and `decode_ready=0`, `instr`, `instr_pc` and `pc_out` are stable.
  - No instruction is lost or duplicated.
- `branch_taken` and `decode_ready` in the same cycle: the branch wins. The current `instr` counts as accepted, and no capture occurs.
- `halt_req` and `branch_taken` in the same cycle: the halt wins and the branch is discarded.
- `halted` asserts in the cycle after the edge that sampled `halt_req`.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds the `perf_fetch_cnt` port and a 16-bit counter behind it.
  - The counter increments on every edge that loads the instruction register (priority case 3).
  - It wraps `16'hFFFF` to `16'h0000`, clears on reset, and freezes in HALTED.
- `FETCH_PERF_EN` undefined:
  - Neither the port nor the counter exists.
  - All other behaviour is identical.

## Test plan
- **Reset and stream.** ROM[0..3] = `A000, A001, A002, A003`; `RESET_PC=0`; `decode_ready=1`. Required: `instr` = `A000, A001, A002, A003` on consecutive cycles, with `instr_pc` = `0, 2, 4, 6`.
- **Stall.**
  - Stimulus: drop `decode_ready` for 3 cycles while `instr=A001`.
  - Required: `instr`, `instr_pc=2` and `pc_out=4` all hold for those cycles.
  - Required: `A002` follows in the cycle after `decode_ready` returns.
- **Branch.**
  - Stimulus: `branch_taken=1`, `branch_target=16'h0011` while `instr=A001` is valid.
  - Required: next cycle `instr_valid=0` and `pc_out=16'h0010`.
  - Required: the cycle after that, `instr=ROM[0x10]` and `instr_pc=16'h0010`.
- **Wrap-around.**
  - Stimulus: `RESET_PC=16'hFFFE`, free-running fetch.
  - Required: `instr_pc` goes `FFFE` then `0000`.
- **Halt.**
  - Stimulus: `halt_req` and `branch_taken` together while `instr_valid=1` and `decode_ready=0`.
  - Required: `halted=1` next cycle, `pc_out` unchanged, `instr` held.
  - Required: raising `decode_ready` clears `instr_valid` permanently.
  - Required: only `reset` resumes fetch, at `RESET_PC`.
- **Perf counter (`FETCH_PERF_EN`).**
  - Stimulus: 5 fetches, a 2-cycle stall, then 1 branch bubble.
  - Required: `perf_fetch_cnt=5`.
  - Required: after reset mid-run, the counter reads 0.
